// File: rtl/kbd_char_writer.sv
// Turns the PS/2 set-2 byte stream into single-cycle char_buffer writes.
// Tracks break/extended prefixes, shift state and the write cursor.
module kbd_char_writer #(
   parameter int COLS  = 12,
   parameter int ROWS  = 9,
   parameter int CELLS = COLS * ROWS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       read_data,
   input  logic       err,
   output logic       wr_en,
   output logic [6:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [6:0] cursor,
   output logic       shift
);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t     state_q, state_d;
   logic       lshift_q, lshift_d;
   logic       rshift_q, rshift_d;
   logic [6:0] cursor_q, cursor_d;
   logic       wr_en_q, wr_en_d;
   logic [6:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;

   logic       accept;
   logic       shift_now;
   logic [8:0] lookup;
   logic [6:0] next_line;
   logic [6:0] cursor_inc;

   // Returns {valid, ascii}; letters are stored lowercase and folded to
   // uppercase afterwards so the table stays one line per key.
   function automatic logic [8:0] to_ascii(input logic [7:0] code, input logic sh);
      logic [7:0] ch;
      logic       hit;
      ch  = 8'h20;
      hit = 1'b1;
      case (code)
         8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;
         8'h23: ch = 8'h64;  8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;
         8'h34: ch = 8'h67;  8'h33: ch = 8'h68;  8'h43: ch = 8'h69;
         8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
         8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;
         8'h4D: ch = 8'h70;  8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;
         8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;  8'h3C: ch = 8'h75;
         8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
         8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
         8'h45: ch = sh ? 8'h29 : 8'h30;
         8'h16: ch = sh ? 8'h21 : 8'h31;
         8'h1E: ch = sh ? 8'h40 : 8'h32;
         8'h26: ch = sh ? 8'h23 : 8'h33;
         8'h25: ch = sh ? 8'h24 : 8'h34;
         8'h2E: ch = sh ? 8'h25 : 8'h35;
         8'h36: ch = sh ? 8'h5E : 8'h36;
         8'h3D: ch = sh ? 8'h26 : 8'h37;
         8'h3E: ch = sh ? 8'h2A : 8'h38;
         8'h46: ch = sh ? 8'h28 : 8'h39;
         8'h29: ch = 8'h20;
         default: hit = 1'b0;
      endcase
      if (sh && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
      return {hit, ch};
   endfunction

   assign accept     = read_data && !err;
   assign shift_now  = lshift_q | rshift_q;
   assign lookup     = to_ascii(rx_data, shift_now);
   assign cursor_inc = (cursor_q == 7'(CELLS - 1)) ? 7'd0 : cursor_q + 7'd1;

   // Start of the following row, found by comparing against row bases.
   always_comb begin
      next_line = 7'd0;
      for (int r = 0; r < ROWS; r++) begin
         if (int'(cursor_q) >= r * COLS) begin
            next_line = (r == ROWS - 1) ? 7'd0 : 7'((r + 1) * COLS);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      lshift_d  = lshift_q;
      rshift_d  = rshift_q;
      cursor_d  = cursor_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (read_data && err) begin
         state_d = IDLE;
      end else if (accept) begin
         case (state_q)
            IDLE: begin
               if (rx_data == 8'hF0) begin
                  state_d = BRK;
               end else if (rx_data == 8'hE0) begin
                  state_d = EXT;
               end else if (rx_data == 8'h12) begin
                  lshift_d = 1'b1;
               end else if (rx_data == 8'h59) begin
                  rshift_d = 1'b1;
               end else if (rx_data == 8'h66) begin
                  if (cursor_q != 7'd0) begin
                     cursor_d  = cursor_q - 7'd1;
                     wr_en_d   = 1'b1;
                     wr_addr_d = cursor_q - 7'd1;
                     wr_data_d = 8'h20;
                  end
               end else if (rx_data == 8'h5A) begin
                  cursor_d = next_line;
               end else if (lookup[8]) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = cursor_q;
                  wr_data_d = lookup[7:0];
                  cursor_d  = cursor_inc;
               end
            end
            BRK: begin
               if (rx_data == 8'h12) lshift_d = 1'b0;
               if (rx_data == 8'h59) rshift_d = 1'b0;
               state_d = IDLE;
            end
            EXT:     state_d = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         lshift_q  <= 1'b0;
         rshift_q  <= 1'b0;
         cursor_q  <= 7'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 7'd0;
         wr_data_q <= 8'h20;
      end else begin
         state_q   <= state_d;
         lshift_q  <= lshift_d;
         rshift_q  <= rshift_d;
         cursor_q  <= cursor_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign cursor  = cursor_q;
   assign shift   = shift_now;

endmodule

// File: doc/kbd_char_writer.md
# kbd_char_writer

Converts the raw PS/2 byte stream from `Ps2Interface` into character-buffer writes for the VGA text display. The block tracks break (F0) and extended (E0) prefixes and shift state, and translates set-2 make codes to ASCII. It maintains the write cursor, including backspace and enter, and drives a single-cycle write port into the display's 12×9 `char_buffer`. It replaces the ad-hoc F0 flag and cursor logic in the display controller, which now only owns storage and rendering.

## Interface
Parameters:
- `COLS`, 12, characters per row
- `ROWS`, 9, number of rows
- `CELLS`, COLS*ROWS (108), buffer size; cursor/address range 0..CELLS-1

Ports:
- `clk`  in  1  100 MHz system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `rx_data`  in  8  byte from Ps2Interface
- `read_data`  in  1  one-cycle strobe, `rx_data` valid
- `err`  in  1  Ps2Interface frame error, qualifies `read_data`
- `wr_en`  out  1  one-cycle write strobe to char buffer
- `wr_addr`  out  7  buffer index for write
- `wr_data`  out  8  ASCII code to write
- `cursor`  out  7  current cursor index (next write position)
- `shift`  out  1  shift currently held (left OR right)

## Operation
- Byte accepted only when `read_data && !err`. If `read_data && err`: byte discarded, decoder returns to `IDLE`, shift unchanged.
- Decoder FSM:
  - `IDLE` → `BRK` on F0; → `EXT` on E0; otherwise make code processed, stay `IDLE`.
  - `BRK`: next byte is a break code; 0x12 clears `lshift`, 0x59 clears `rshift`, others ignored; → `IDLE`.
  - `EXT`: F0 → `EXT_BRK`; any other byte ignored → `IDLE`.
  - `EXT_BRK`: byte ignored → `IDLE`. All extended keys are ignored.
- Make codes in `IDLE`:
  - 0x12 sets `lshift`; 0x59 sets `rshift`. `shift` = `lshift | rshift`. No write.
  - Printable key (set-2 letters, digits, space 0x29): ASCII via internal combinational table.
    - Letters: lowercase when `shift`=0, uppercase when `shift`=1.
    - Digits: '0'–'9' unshifted; shifted gives US symbols `)!@#$%^&*(`.
    - Space: 0x20 regardless of shift.
    - Write `wr_data`=ASCII, `wr_addr`=`cursor`, then `cursor` += 1, wrapping CELLS-1 → 0.
  - Backspace 0x66: if `cursor`>0, `cursor` −= 1 and write 0x20 at the new cursor. At `cursor`=0: no write, no move.
  - Enter 0x5A: no write; `cursor` = (row+1)*COLS, where row = cursor/COLS. From the last row it wraps to 0.
  - Any unmapped code: ignored.
- Typematic repeats (repeated make without break) are processed as new presses.
- A stray F0 or E0 while in `BRK`/`EXT`/`EXT_BRK` is consumed as the data byte of that state; no nesting.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0x20, `cursor`=0, `shift`=0, `lshift`=`rshift`=0, FSM=`IDLE`. Reset overrides any concurrent `read_data`.
- Latency: a byte accepted at edge N produces registered `wr_en`=1 with its `wr_addr`/`wr_data` valid during cycle N+1, for exactly one cycle. `cursor` updates on the same edge.
- `wr_addr` and `wr_data` hold their last values while `wr_en`=0.
- At most one byte per `read_data` strobe. Strobes are ≥1 PS/2 bit-time apart, so no back-to-back case arises; the design still handles strobes on consecutive cycles with one write per cycle.
- Arithmetic: row computed by compare/subtract against multiples of COLS (no divider). Cursor is always < CELLS.

## Test plan
- Reset, then bytes 0x1C, F0, 0x1C → one write: `wr_addr`=0, `wr_data`=0x61 ('a'). After that, `cursor`=1.
- 0x12, 0x32, F0, 0x32, F0, 0x12, 0x32 → writes 0x42 at 0 and 0x62 at 1. `shift` is 1 only between 0x12 and its break.
- Cursor at 107, key 0x16 → write 0x31 at 107 and `cursor`=0. Then Enter at `cursor`=100 → `cursor`=0 with no write.
- `cursor`=13, 0x66 → write 0x20 at 12 and `cursor`=12. At `cursor`=0, 0x66 → no `wr_en`, `cursor` stays 0.
- E0, 0x75, E0, F0, 0x75, then 0x29 → only one write (0x20 at cursor). F0 with `err`=1, then 0x1C → 'a' written, because the error cleared the pending break.
- `reset` asserted in the cycle of a valid `read_data` → no `wr_en` next cycle and all outputs at reset values.
